// File: rtl/bcd_converter.sv
// Sequential 20-bit binary to six-digit BCD converter (double-dabble, one iteration per clock).
// The result register only updates when a conversion completes, so the display never sees partial digits.
module bcd_converter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [19:0] bin,
    output logic [23:0] bcd,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic        overflow
);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t      state_q;
    logic [19:0] shift_q;
    logic [23:0] scratch_q;
    logic [4:0]  cnt_q;
    logic        ovf_pending_q;
    logic [23:0] bcd_q;
    logic        done_q;
    logic        valid_q;
    logic        overflow_q;

    logic [22:0] adj;
    logic [23:0] scratch_d;
    logic [19:0] shift_d;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_digit_adj
            assign adj[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5) ?
                                    scratch_q[gi*4 +: 4] + 4'd3 : scratch_q[gi*4 +: 4];
        end
    endgenerate

    // The top digit's bit 3 would shift into a seventh digit, so only its low three bits are kept.
    assign adj[22:20] = (scratch_q[23:20] >= 4'd5) ? scratch_q[22:20] + 3'd3 : scratch_q[22:20];

    assign scratch_d = {adj, shift_q[19]};
    assign shift_d   = {shift_q[18:0], 1'b0};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            scratch_q     <= '0;
            cnt_q         <= '0;
            ovf_pending_q <= 1'b0;
            bcd_q         <= '0;
            done_q        <= 1'b0;
            valid_q       <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_q       <= bin;
                        scratch_q     <= '0;
                        cnt_q         <= '0;
                        ovf_pending_q <= (bin > 20'd999999);
                        state_q       <= CONV;
                    end
                end
                CONV: begin
                    scratch_q <= scratch_d;
                    shift_q   <= shift_d;
                    cnt_q     <= cnt_q + 5'd1;
                    if (cnt_q == 5'd19) begin
                        bcd_q      <= ovf_pending_q ? 24'h999999 : scratch_d;
                        overflow_q <= ovf_pending_q;
                        valid_q    <= 1'b1;
                        done_q     <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bcd      = bcd_q;
    assign busy     = (state_q == CONV);
    assign done     = done_q;
    assign valid    = valid_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_converter.sv
// Randomized self-checking bench for bcd_converter; expected digits come from decimal arithmetic.
module tb_bcd_converter;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [19:0] bin;
    logic [23:0] bcd;
    logic        busy;
    logic        done;
    logic        valid;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    bcd_converter dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .bin      (bin),
        .bcd      (bcd),
        .busy     (busy),
        .done     (done),
        .valid    (valid),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal digits by repeated division; values above 999999 saturate.
    function automatic logic [23:0] ref_bcd(input int unsigned v);
        int unsigned x;
        logic [23:0] r;
        x = (v > 999999) ? 999999 : v;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Issues one start pulse and waits for done; lat = edges from the start edge to the done edge, -1 on timeout.
    task automatic launch(input logic [19:0] v, output int lat, output int busy_cyc, output logic bcd_moved);
        logic [23:0] prev;
        @(negedge clk);
        prev  = bcd;
        start = 1'b1;
        bin   = v;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        busy_cyc = 0;
        bcd_moved = 1'b0;
        for (int e = 0; e <= 40; e++) begin
            bin = 20'($urandom);
            if (done) begin
                lat = e;
                break;
            end
            if (busy) busy_cyc++;
            if (bcd !== prev) bcd_moved = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0;
        bin = '0;
        #1;
        checks++;
        if ({bcd, busy, done, valid, overflow} !== 28'h0) begin
            errors++;
            $display("FAIL reset_outputs: got bcd=%h busy=%b done=%b valid=%b ovf=%b, want all 0",
                     bcd, busy, done, valid, overflow);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        $display("reset: bcd=%h busy=%b valid=%b", bcd, busy, valid);
    endtask

    task automatic test_zero();
        int lat, bc;
        logic moved;
        launch(20'd0, lat, bc, moved);
        checks++;
        if (lat !== 20) begin
            errors++;
            $display("FAIL zero_latency: got %0d, want 20", lat);
        end
        checks++;
        if ({bcd, overflow, valid, busy} !== {24'h000000, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL zero_result: got bcd=%h ovf=%b valid=%b busy=%b, want 000000 0 1 0",
                     bcd, overflow, valid, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_single_cycle: got done=%b, want 0", done);
        end
        $display("conv bin=0 bcd=%h lat=%0d", bcd, lat);
    endtask

    task automatic test_hold_stable();
        int lat, bc;
        logic moved;
        launch(20'd123456, lat, bc, moved);
        checks++;
        if (bcd !== 24'h123456 || lat !== 20) begin
            errors++;
            $display("FAIL conv_123456: got bcd=%h lat=%0d, want 123456 lat 20", bcd, lat);
        end
        checks++;
        if (bc !== 20) begin
            errors++;
            $display("FAIL busy_width: got %0d cycles, want 20", bc);
        end
        checks++;
        if (moved !== 1'b0) begin
            errors++;
            $display("FAIL bcd_stable_in_conv: got moved=%b, want 0", moved);
        end
        $display("conv bin=123456 bcd=%h busy_cycles=%0d", bcd, bc);
    endtask

    task automatic test_boundary();
        logic [19:0] vals [3] = '{20'd999999, 20'd1000000, 20'hFFFFF};
        int lat, bc;
        logic moved;
        for (int i = 0; i < 3; i++) begin
            launch(vals[i], lat, bc, moved);
            checks++;
            if (bcd !== ref_bcd(vals[i]) || overflow !== (vals[i] > 20'd999999) || lat !== 20) begin
                errors++;
                $display("FAIL boundary_%0d: got bcd=%h ovf=%b lat=%0d, want %h ovf=%b lat 20",
                         vals[i], bcd, overflow, lat, ref_bcd(vals[i]), vals[i] > 20'd999999);
            end
            $display("conv bin=%0d bcd=%h ovf=%b", vals[i], bcd, overflow);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned vals [3] = '{42, 7, 65535};
        int d = 0;
        int last = 0;
        @(negedge clk);
        start = 1'b1;
        bin = 20'(vals[0]);
        for (int cyc = 1; cyc <= 90 && d < 3; cyc++) begin
            @(negedge clk);
            if (done) begin
                checks++;
                if (bcd !== ref_bcd(vals[d]) || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_result_%0d: got bcd=%h busy=%b, want %h busy=0",
                             d, bcd, busy, ref_bcd(vals[d]));
                end
                if (d > 0) begin
                    checks++;
                    if (cyc - last !== 21) begin
                        errors++;
                        $display("FAIL b2b_spacing_%0d: got %0d, want 21", d, cyc - last);
                    end
                end
                $display("b2b bin=%0d bcd=%h spacing=%0d", vals[d], bcd, cyc - last);
                last = cyc;
                d++;
                if (d < 3) bin = 20'(vals[d]);
                else start = 1'b0;
            end
        end
        start = 1'b0;
        checks++;
        if (d !== 3) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d done pulses, want 3", d);
        end
    endtask

    task automatic test_ignored_start();
        int pulses = 0;
        int first = -1;
        @(negedge clk);
        start = 1'b1;
        bin = 20'd500000;
        for (int e = 0; e <= 45; e++) begin
            @(negedge clk);
            start = (e == 4);
            bin = (e == 4) ? 20'd1 : 20'($urandom);
            if (done) begin
                pulses++;
                if (first < 0) begin
                    first = e;
                    checks++;
                    if (bcd !== 24'h500000) begin
                        errors++;
                        $display("FAIL ignored_result: got %h, want 500000", bcd);
                    end
                end
            end
        end
        start = 1'b0;
        checks++;
        if (pulses !== 1 || first !== 20) begin
            errors++;
            $display("FAIL ignored_done_count: got pulses=%0d at %0d, want 1 at 20", pulses, first);
        end
        $display("conv bin=500000 with mid start: bcd=%h pulses=%0d", bcd, pulses);
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int lat = -1;
        @(negedge clk);
        start = 1'b1;
        bin = 20'd654321;
        @(negedge clk);
        start = 1'b0;
        repeat (9) begin
            @(negedge clk);
            if (done) seen++;
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({bcd, busy, done, valid, overflow} !== 28'h0) begin
            errors++;
            $display("FAIL async_reset: got bcd=%h busy=%b done=%b valid=%b ovf=%b, want all 0",
                     bcd, busy, done, valid, overflow);
        end
        repeat (2) begin
            @(negedge clk);
            if (done) seen++;
        end
        reset_n = 1'b1;
        start = 1'b1;
        bin = 20'd17;
        @(negedge clk);
        start = 1'b0;
        for (int e = 0; e <= 40; e++) begin
            if (done) begin
                lat = e;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d pulses, want 0", seen);
        end
        checks++;
        if (bcd !== 24'h000017 || lat !== 20) begin
            errors++;
            $display("FAIL after_reset_17: got bcd=%h lat=%0d, want 000017 lat 20", bcd, lat);
        end
        $display("reset mid-conv then bin=17 bcd=%h lat=%0d", bcd, lat);
    endtask

    task automatic test_random();
        int lat, bc;
        logic moved;
        logic [19:0] v;
        for (int i = 0; i < 12; i++) begin
            case (i % 3)
                0: v = 20'($urandom_range(0, 20'hFFFFF));
                1: v = 20'($urandom_range(999990, 1000010));
                default: v = 20'($urandom_range(0, 9999));
            endcase
            launch(v, lat, bc, moved);
            checks++;
            if (bcd !== ref_bcd(v) || overflow !== (v > 20'd999999) || lat !== 20 || moved !== 1'b0) begin
                errors++;
                $display("FAIL random_%0d: bin=%0d got bcd=%h ovf=%b lat=%0d moved=%b, want %h ovf=%b lat 20",
                         i, v, bcd, overflow, lat, moved, ref_bcd(v), v > 20'd999999);
            end
            $display("rand bin=%0d bcd=%h ovf=%b", v, bcd, overflow);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_hold_stable();
        test_boundary();
        test_back_to_back();
        test_ignored_start();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
